hud_stats_tracker: RTL and testbench
====================================

# hud_stats_tracker

Game-state producer feeding the HUD sprite renderer. It converts per-frame collision levels from the gameplay logic into the values the HUD draws: ring count and per-ring collected mask, the elapsed-time counter with BCD digits, lives, the finish bonus, and the end_game/time_over flags. The block runs in the frame_clk domain, one update per frame, and sits between the collision logic and the renderer.

## Interface
- NUM_RINGS, 8: number of placed rings tracked.
- TIME_LIMIT_FRAMES, 14400: frame count at which the game times out.
- FAST_FINISH_FRAMES, 1800: a finish at or below this frame count earns the fast bonus.
- START_LIVES, 3: lives after reset, range 1..9.
- INVULN_FRAMES, 120: length of the post-hit invulnerability window.
- frame_clk  in  1  frame-rate clock; sole clock.
- Reset  in  1  synchronous, active-high reset.
- ring_hit  in  NUM_RINGS  level; bit i is high while Sonic overlaps ring i.
- spike_hit  in  1  level; high while Sonic overlaps a spike.
- goal_hit  in  1  level; high while Sonic overlaps the goal.
- rings  out  7  ring count, 0..99.
- collected  out  NUM_RINGS  bit i is set once ring i has been consumed.
- game_time  out  14  elapsed frames.
- time_min, time_sec_tens, time_sec_ones  out  4 each  BCD elapsed time m:ss.
- lives  out  4  lives remaining.
- bonus  out  3  finish bonus; 0, 3, or 5.
- end_game  out  1  goal reached.
- time_over  out  1  game lost, either by time limit or by running out of lives.
- invuln  out  1  invulnerability window active.

## Operation
- The FSM has four states: PLAY, HURT, CLEAR, OVER. Reset enters PLAY.
- Edge detection:
  - ring_hit, spike_hit and goal_hit are registered each frame; an event is a 0→1 transition.
  - The previous-value registers reset to 0, so an input that is high in the first frame after reset counts as an edge.
- Ring collection, active in PLAY and HURT:
  - A new ring is a bit with a rising edge on ring_hit[i] while collected[i] is 0. Each new ring sets collected[i].
  - rings increases by the popcount of new rings and saturates at 99.
  - A ring already marked in collected never counts again, whatever the level of ring_hit.
- Spike hit, on a spike_hit edge in PLAY (ignored in HURT):
  - If rings > 0: rings becomes 0. The FSM enters HURT and the invulnerability timer loads INVULN_FRAMES-1.
  - If rings == 0: lives decrements. If the result is 0, go to OVER and set time_over=1; otherwise enter HURT as above.
  - The spike decision uses the rings value from before the frame. Rings collected in the same frame set their collected bits but are not added to the count.
- HURT: invuln=1 and the timer counts down; when it reaches 0 the FSM returns to PLAY.
- Goal: a goal_hit edge in PLAY or HURT moves the FSM to CLEAR and sets end_game=1.
  - bonus = 5 if game_time ≤ FAST_FINISH_FRAMES, else 3.
  - invuln drops to 0.
- Timer:
  - game_time increments once per frame in PLAY and HURT.
  - When the pre-increment value equals TIME_LIMIT_FRAMES-1, the FSM goes to OVER, time_over=1, and game_time holds at TIME_LIMIT_FRAMES.
- Priority within one frame, highest first: goal > time limit > spike > ring count.
- CLEAR and OVER are terminal until Reset; every counter and output is frozen in both.
- BCD digits:
  - A 0..59 frame prescaler drives the chain sec_ones (0..9) → sec_tens (0..5) → min (0..9, saturating).
  - The digits must always equal game_time/3600, (game_time%3600)/600 and (game_time/60)%10, up to saturation.

## Timing
- All outputs are registered. An input level sampled at edge n appears on the outputs at edge n; one frame of latency from the collision source.
- Reset values:
  - rings=0, collected=0, game_time=0, all BCD digits=0.
  - lives=START_LIVES, bonus=0.
  - end_game=0, time_over=0, invuln=0.
- Reset asserted mid-game restores every reset value on the next frame_clk edge, from any state including CLEAR and OVER.
- The time limit and a spike hit landing in the same frame resolve to OVER. time_over is set once, and lives still decrements if rings was 0.

## Configuration
- STATS_INVULN_EN defined: the HURT state and invulnerability timer exist, as described above.
- STATS_INVULN_EN undefined:
  - HURT and its timer are removed; invuln is tied to 0.
  - The spike action is unchanged except that the FSM stays in PLAY.
  - Every spike_hit rising edge is processed.

## Structure
- Package hud_stats_pkg holds:
  - the stats_state_t enum (PLAY, HURT, CLEAR, OVER);
  - RING_MAX=99;
  - the bonus constants BONUS_FAST=5 and BONUS_NORMAL=3.
- Sub-module bcd_time_counter holds the 60-frame prescaler and the three-digit BCD chain. Its inputs are frame_clk, Reset and an enable; its outputs are the three digits.

## Test plan
- Reset, then ring_hit[2] held high for 5 frames, then low, then high again → rings=1 after the first frame; collected=8'b0000_0100; no further increment.
- ring_hit=8'b0000_1011 rising in one frame with rings=97 → rings=99 (saturated); collected=8'b0000_1011.
- rings=5, spike edge → rings=0, invuln=1 for 120 frames; a second spike edge inside the window leaves lives=3; a spike edge after the window with rings=0 → lives=2.
- lives=1, rings=0, spike edge → lives=0, time_over=1; state frozen; then Reset → lives=3, time_over=0.
- Run 3725 frames, then goal edge → time_min=1, time_sec_tens=0, time_sec_ones=2, bonus=3, end_game=1; game_time stays at 3725 afterwards.
- Goal edge in the same frame that game_time=14399 → end_game=1, time_over=0.

Source files
------------

// File: rtl/hud_stats_pkg.sv
// Shared types and constants for the HUD stats tracker: FSM states, ring ceiling,
// finish-bonus values and the one-second frame prescaler bound.
package hud_stats_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    HURT  = 2'd1,
    CLEAR = 2'd2,
    OVER  = 2'd3
  } stats_state_t;

  localparam logic [6:0] RING_MAX       = 7'd99;
  localparam logic [2:0] BONUS_FAST     = 3'd5;
  localparam logic [2:0] BONUS_NORMAL   = 3'd3;
  localparam logic [5:0] PRESCALE_LAST  = 6'd59;

  // Ring counter add that clamps at the two-digit HUD limit.
  function automatic logic [6:0] ring_sat_add(input logic [6:0] cur, input logic [7:0] inc);
    logic [8:0] sum;
    sum = {2'b00, cur} + {1'b0, inc};
    return (sum > {2'b00, RING_MAX}) ? RING_MAX : sum[6:0];
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Elapsed-time display counter: 60-frame prescaler feeding an m:ss BCD chain.
// Minutes saturate at 9; the display then holds at 9:59.
module bcd_time_counter
  import hud_stats_pkg::*;
(
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       en,
  output logic [3:0] time_min,
  output logic [3:0] time_sec_tens,
  output logic [3:0] time_sec_ones
);

  logic [5:0] prescale;
  logic       at_max;

  assign at_max = (time_min == 4'd9) && (time_sec_tens == 4'd5) && (time_sec_ones == 4'd9);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prescale      <= '0;
      time_min      <= '0;
      time_sec_tens <= '0;
      time_sec_ones <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so the digit carries below see the same prescale value regardless of order.
      prescale <= (prescale == PRESCALE_LAST) ? 6'd0 : prescale + 6'd1;
      if ((prescale == PRESCALE_LAST) && !at_max) begin
        if (time_sec_ones == 4'd9) begin
          time_sec_ones <= 4'd0;
          if (time_sec_tens == 4'd5) begin
            time_sec_tens <= 4'd0;
            time_min      <= time_min + 4'd1;
          end else begin
            time_sec_tens <= time_sec_tens + 4'd1;
          end
        end else begin
          time_sec_ones <= time_sec_ones + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/hud_stats_tracker.sv
// Per-frame HUD game state: rings, elapsed time, lives, finish bonus and end flags.
// Define STATS_INVULN_EN to build the HURT state with its post-hit invulnerability window.
module hud_stats_tracker
  import hud_stats_pkg::*;
#(
  parameter int NUM_RINGS          = 8,
  parameter int TIME_LIMIT_FRAMES  = 14400,
  parameter int FAST_FINISH_FRAMES = 1800,
  parameter int START_LIVES        = 3,
  parameter int INVULN_FRAMES      = 120
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [NUM_RINGS-1:0] ring_hit,
  input  logic                 spike_hit,
  input  logic                 goal_hit,
  output logic [6:0]           rings,
  output logic [NUM_RINGS-1:0] collected,
  output logic [13:0]          game_time,
  output logic [3:0]           time_min,
  output logic [3:0]           time_sec_tens,
  output logic [3:0]           time_sec_ones,
  output logic [3:0]           lives,
  output logic [2:0]           bonus,
  output logic                 end_game,
  output logic                 time_over,
  output logic                 invuln
);

  localparam logic [13:0] TIME_LAST  = 14'(TIME_LIMIT_FRAMES - 1);
  localparam logic [13:0] TIME_CAP   = 14'(TIME_LIMIT_FRAMES);
  localparam logic [13:0] FAST_MAX   = 14'(FAST_FINISH_FRAMES);
  localparam logic [3:0]  LIVES_INIT = 4'(START_LIVES);

  stats_state_t         state, state_nx;
  logic [NUM_RINGS-1:0] ring_prev, ring_rise, new_rings, collected_nx;
  logic                 spike_prev, goal_prev, spike_rise, goal_rise, spike_act;
  logic [7:0]           new_count;
  logic [6:0]           rings_nx;
  logic [13:0]          game_time_nx;
  logic [3:0]           lives_nx;
  logic [2:0]           bonus_nx;
  logic                 end_game_nx, time_over_nx, time_en;

`ifdef STATS_INVULN_EN
  localparam int                 TIMER_W    = $clog2(INVULN_FRAMES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_FRAMES - 1);
  logic [TIMER_W-1:0] timer, timer_nx;
`else
  logic [7:0] unused_invuln_frames;
  assign unused_invuln_frames = 8'(INVULN_FRAMES);
  assign invuln = 1'b0;
`endif

  // Previous levels clear on reset so a level already high in the first frame is an edge.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      ring_prev  <= '0;
      spike_prev <= 1'b0;
      goal_prev  <= 1'b0;
    end else begin
      ring_prev  <= ring_hit;
      spike_prev <= spike_hit;
      goal_prev  <= goal_hit;
    end
  end

  assign ring_rise  = ring_hit & ~ring_prev;
  assign spike_rise = spike_hit & ~spike_prev;
  assign goal_rise  = goal_hit & ~goal_prev;
  assign new_rings  = ring_rise & ~collected;

  always_comb begin
    new_count = '0;
    for (int i = 0; i < NUM_RINGS; i++) begin
      new_count = new_count + {7'd0, new_rings[i]};
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) state <= PLAY;
    else       state <= state_nx;
  end

  // Priority: goal, then time limit, then spike, then ring count.
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves one
    // unassigned would infer a latch.
    state_nx     = state;
    rings_nx     = rings;
    collected_nx = collected;
    game_time_nx = game_time;
    lives_nx     = lives;
    bonus_nx     = bonus;
    end_game_nx  = end_game;
    time_over_nx = time_over;
    time_en      = 1'b0;
`ifdef STATS_INVULN_EN
    timer_nx     = timer;
    spike_act    = spike_rise && (state == PLAY);
`else
    spike_act    = spike_rise;
`endif

    if ((state == PLAY) || (state == HURT)) begin
      if (goal_rise) begin
        state_nx    = CLEAR;
        end_game_nx = 1'b1;
        bonus_nx    = (game_time <= FAST_MAX) ? BONUS_FAST : BONUS_NORMAL;
      end else begin
        time_en      = 1'b1;
        collected_nx = collected | new_rings;
        if (game_time == TIME_LAST) begin
          game_time_nx = TIME_CAP;
          state_nx     = OVER;
          time_over_nx = 1'b1;
        end else begin
          game_time_nx = game_time + 14'd1;
        end

        // The spike decision uses the pre-frame ring count; same-frame rings are not added.
        if (spike_act) begin
          if (rings != '0) begin
            rings_nx = '0;
          end else begin
            lives_nx = lives - 4'd1;
            if (lives == 4'd1) begin
              state_nx     = OVER;
              time_over_nx = 1'b1;
            end
          end
`ifdef STATS_INVULN_EN
          if (state_nx != OVER) begin
            state_nx = HURT;
            timer_nx = TIMER_LOAD;
          end
`endif
        end else begin
          rings_nx = ring_sat_add(rings, new_count);
`ifdef STATS_INVULN_EN
          if ((state == HURT) && (state_nx != OVER)) begin
            if (timer == '0) state_nx = PLAY;
            else             timer_nx = timer - TIMER_W'(1);
          end
`endif
        end
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      rings     <= '0;
      collected <= '0;
      game_time <= '0;
      lives     <= LIVES_INIT;
      bonus     <= '0;
      end_game  <= 1'b0;
      time_over <= 1'b0;
`ifdef STATS_INVULN_EN
      timer     <= '0;
      invuln    <= 1'b0;
`endif
    end else begin
      rings     <= rings_nx;
      collected <= collected_nx;
      game_time <= game_time_nx;
      lives     <= lives_nx;
      bonus     <= bonus_nx;
      end_game  <= end_game_nx;
      time_over <= time_over_nx;
`ifdef STATS_INVULN_EN
      timer     <= timer_nx;
      invuln    <= (state_nx == HURT);
`endif
    end
  end

  bcd_time_counter u_time (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .en            (time_en),
    .time_min      (time_min),
    .time_sec_tens (time_sec_tens),
    .time_sec_ones (time_sec_ones)
  );

endmodule

// File: tb/tb_hud_stats_tracker.sv
// Directed bench for hud_stats_tracker; a wide ring vector lets the count reach saturation.
module tb_hud_stats_tracker;

  localparam int NR = 105;
`ifdef STATS_INVULN_EN
  localparam int INV_EN = 1;
`else
  localparam int INV_EN = 0;
`endif

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [NR-1:0] ring_hit;
  logic          spike_hit;
  logic          goal_hit;
  logic [6:0]    rings;
  logic [NR-1:0] collected;
  logic [13:0]   game_time;
  logic [3:0]    time_min, time_sec_tens, time_sec_ones;
  logic [3:0]    lives;
  logic [2:0]    bonus;
  logic          end_game, time_over, invuln;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 frame_clk = ~frame_clk;

  hud_stats_tracker #(
    .NUM_RINGS          (NR),
    .TIME_LIMIT_FRAMES  (14400),
    .FAST_FINISH_FRAMES (1800),
    .START_LIVES        (3),
    .INVULN_FRAMES      (120)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .ring_hit      (ring_hit),
    .spike_hit     (spike_hit),
    .goal_hit      (goal_hit),
    .rings         (rings),
    .collected     (collected),
    .game_time     (game_time),
    .time_min      (time_min),
    .time_sec_tens (time_sec_tens),
    .time_sec_ones (time_sec_ones),
    .lives         (lives),
    .bonus         (bonus),
    .end_game      (end_game),
    .time_over     (time_over),
    .invuln        (invuln)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge frame_clk);
      @(negedge frame_clk);
    end
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    ring_hit  = '0;
    spike_hit = 1'b0;
    goal_hit  = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic check_time(input string tag, input int gt, input int m, input int t, input int o);
    check({tag, "_frames"}, 32'(game_time), gt);
    check({tag, "_min"}, 32'(time_min), m);
    check({tag, "_tens"}, 32'(time_sec_tens), t);
    check({tag, "_ones"}, 32'(time_sec_ones), o);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_rings", 32'(rings), 0);
    check("rst_collected_lo", 32'(collected[31:0]), 0);
    check_time("rst", 0, 0, 0, 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_bonus", 32'(bonus), 0);
    check("rst_end_game", 32'(end_game), 0);
    check("rst_time_over", 32'(time_over), 0);
    check("rst_invuln", 32'(invuln), 0);

    // Held ring counts once; dropping and re-raising does not recount
    ring_hit[2] = 1'b1;
    tick();
    check("ring2_first", 32'(rings), 1);
    check("ring2_collected", 32'(collected[7:0]), 32'h04);
    tick(4);
    check("ring2_held", 32'(rings), 1);
    ring_hit[2] = 1'b0;
    tick();
    ring_hit[2] = 1'b1;
    tick();
    check("ring2_reraise", 32'(rings), 1);
    check("frames_7", 32'(game_time), 7);

    // Saturation at 99
    do_reset();
    ring_hit[NR-1:8] = '1;
    tick();
    check("ring97", 32'(rings), 97);
    ring_hit[7:0] = 8'b0000_1011;
    tick();
    check("ring_sat", 32'(rings), 99);
    check("sat_collected_lo", 32'(collected[7:0]), 32'h0B);
    check("sat_collected_hi", 32'(&collected[NR-1:8]), 1);

    // Spike with rings, window, spike after window
    do_reset();
    ring_hit[4:0] = 5'b11111;
    tick();
    check("ring5", 32'(rings), 5);
    spike_hit = 1'b1;
    tick();
    check("spike_clears", 32'(rings), 0);
    check("spike_keeps_lives", 32'(lives), 3);
    check("invuln_on", 32'(invuln), INV_EN);
    spike_hit = 1'b0;
    tick();
    spike_hit = 1'b1;
    tick();
    check("spike_in_window", 32'(lives), INV_EN ? 3 : 2);
    spike_hit = 1'b0;
    tick(117);
    check("invuln_last", 32'(invuln), INV_EN);
    tick();
    check("invuln_off", 32'(invuln), 0);
    spike_hit = 1'b1;
    tick();
    check("spike_after_window", 32'(lives), INV_EN ? 2 : 1);
    spike_hit = 1'b0;

    // Lose all lives, frozen in OVER, then reset
    do_reset();
    for (int k = 0; k < 3; k++) begin
      spike_hit = 1'b1;
      tick();
      spike_hit = 1'b0;
      if (k == 1) check("lives_1", 32'(lives), 1);
      if (k < 2) tick(125);
    end
    check("dead_lives", 32'(lives), 0);
    check("dead_time_over", 32'(time_over), 1);
    check("dead_frames", 32'(game_time), 253);
    ring_hit[0] = 1'b1;
    goal_hit    = 1'b1;
    tick(5);
    check("over_frozen_frames", 32'(game_time), 253);
    check("over_frozen_rings", 32'(rings), 0);
    check("over_frozen_end", 32'(end_game), 0);
    check("over_frozen_lives", 32'(lives), 0);
    do_reset();
    check("reset_from_over_lives", 32'(lives), 3);
    check("reset_from_over_to", 32'(time_over), 0);
    check("reset_from_over_frames", 32'(game_time), 0);

    // 3725 frames then goal: 1:02, normal bonus, frozen
    tick(3725);
    check_time("t3725", 3725, 1, 0, 2);
    goal_hit = 1'b1;
    tick();
    check("goal_end_game", 32'(end_game), 1);
    check("goal_bonus_normal", 32'(bonus), 3);
    check("goal_invuln", 32'(invuln), 0);
    goal_hit = 1'b0;
    tick(10);
    check_time("clear_frozen", 3725, 1, 0, 2);

    // Fast-bonus boundary
    do_reset();
    tick(1800);
    goal_hit = 1'b1;
    tick();
    check("bonus_at_1800", 32'(bonus), 5);
    do_reset();
    tick(1801);
    goal_hit = 1'b1;
    tick();
    check("bonus_at_1801", 32'(bonus), 3);

    // Goal on the time-limit frame wins
    do_reset();
    tick(14399);
    check_time("t14399", 14399, 3, 5, 9);
    goal_hit = 1'b1;
    tick();
    check("limit_goal_end", 32'(end_game), 1);
    check("limit_goal_to", 32'(time_over), 0);
    check("limit_goal_frames", 32'(game_time), 14399);
    do_reset();
    check("reset_from_clear_end", 32'(end_game), 0);
    check("reset_from_clear_bonus", 32'(bonus), 0);

    // Time limit with a zero-ring spike in the same frame
    tick(14399);
    spike_hit = 1'b1;
    tick();
    check("timeout_to", 32'(time_over), 1);
    check("timeout_lives", 32'(lives), 2);
    check("timeout_invuln", 32'(invuln), 0);
    check_time("timeout", 14400, 4, 0, 0);
    spike_hit = 1'b0;
    tick(3);
    check("timeout_hold", 32'(game_time), 14400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
